// File: rtl/pre_proc_scheduler_pkg.sv
// Shared types and defaults for the projection pre-processor frame sequencer.
package pre_proc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    ISSUE,
    WAIT_RESULT,
    DONE
  } sched_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/pre_proc_scheduler_if.sv
// Control, memory, pre-processor and rasterizer handshakes of the scheduler.
interface pre_proc_scheduler_if #(
  parameter int TRI_ID_WIDTH = 16,
  parameter int CNT_WIDTH    = 16
) ();

  logic                    start_in;
  logic [TRI_ID_WIDTH-1:0] num_tris_in;
  logic                    busy_out;
  logic                    done_out;
  logic                    fetch_valid_out;
  logic [TRI_ID_WIDTH-1:0] fetch_addr_out;
  logic                    fetch_ready_in;
  logic                    fetch_data_valid_in;
  logic                    pp_valid_out;
  logic                    pp_ready_in;
  logic                    pp_valid_in;
  logic                    pp_short_circuit_in;
  logic                    pp_ready_out;
  logic                    pp_flush_out;
  logic                    rast_valid_out;
  logic                    rast_ready_in;
  logic [TRI_ID_WIDTH-1:0] rast_tri_id_out;
  logic [CNT_WIDTH-1:0]    emitted_count_out;
  logic [CNT_WIDTH-1:0]    culled_count_out;
  logic [CNT_WIDTH-1:0]    timeout_count_out;
  logic                    error_out;

  modport master (
    input  start_in, num_tris_in, fetch_ready_in, fetch_data_valid_in,
           pp_ready_in, pp_valid_in, pp_short_circuit_in, rast_ready_in,
    output busy_out, done_out, fetch_valid_out, fetch_addr_out, pp_valid_out,
           pp_ready_out, pp_flush_out, rast_valid_out, rast_tri_id_out,
           emitted_count_out, culled_count_out, timeout_count_out, error_out
  );

  modport slave (
    output start_in, num_tris_in, fetch_ready_in, fetch_data_valid_in,
           pp_ready_in, pp_valid_in, pp_short_circuit_in, rast_ready_in,
    input  busy_out, done_out, fetch_valid_out, fetch_addr_out, pp_valid_out,
           pp_ready_out, pp_flush_out, rast_valid_out, rast_tri_id_out,
           emitted_count_out, culled_count_out, timeout_count_out, error_out
  );

endinterface

// File: rtl/pre_proc_scheduler_sat_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
// Latency: count reflects clr/inc one cycle after they are sampled.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pre_proc_scheduler.sv
// Frame sequencer: fetch, issue and collect one triangle at a time, forwarding projected ones.
// Latency: >= 3 cycles per triangle (FETCH, WAIT_DATA, ISSUE) plus pre-processor latency.
// Backpressure: rast_ready_in passes straight to pp_ready_out; stalls count toward the watchdog.
module pre_proc_scheduler
  import pre_proc_sched_pkg::*;
#(
  parameter int TRI_ID_WIDTH   = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic                  clk_in,
  input logic                  rst_n_in,
  pre_proc_scheduler_if.master bus
);

  sched_state_t            state;
  logic [TRI_ID_WIDTH-1:0] idx, num_tris, fetch_addr, rast_tri_id;
  logic [TO_WIDTH-1:0]     wd_cnt;
  logic [CNT_WIDTH-1:0]    emitted_cnt, culled_cnt, timeout_cnt;
  logic busy, done, fetch_valid, pp_valid, flush, error;
  logic in_result, cull_ev, emit_ev, timeout_ev, advance, last_tri, start_acc;

  assign in_result  = (state == WAIT_RESULT);
  // Short-circuit takes priority over a coincident valid result.
  assign cull_ev    = in_result & bus.pp_short_circuit_in;
  assign emit_ev    = in_result & ~bus.pp_short_circuit_in & bus.pp_valid_in & bus.rast_ready_in;
  assign timeout_ev = in_result & ~cull_ev & ~emit_ev &
                      (wd_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign advance    = cull_ev | emit_ev | timeout_ev;
  assign last_tri   = (idx == num_tris - TRI_ID_WIDTH'(1));
  assign start_acc  = (state == IDLE) & bus.start_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      idx         <= '0;
      num_tris    <= '0;
      fetch_addr  <= '0;
      rast_tri_id <= '0;
      wd_cnt      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fetch_valid <= 1'b0;
      pp_valid    <= 1'b0;
      flush       <= 1'b0;
      error       <= 1'b0;
    end else begin
      done  <= 1'b0;
      flush <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            num_tris <= bus.num_tris_in;
            error    <= 1'b0;
            idx      <= '0;
            busy     <= 1'b1;
            if (bus.num_tris_in == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= FETCH;
              fetch_valid <= 1'b1;
              fetch_addr  <= '0;
            end
          end
        end
        FETCH: begin
          if (bus.fetch_ready_in) begin
            fetch_valid <= 1'b0;
            state       <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (bus.fetch_data_valid_in) begin
            pp_valid <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.pp_ready_in) begin
            pp_valid    <= 1'b0;
            wd_cnt      <= '0;
            rast_tri_id <= idx;
            state       <= WAIT_RESULT;
          end
        end
        WAIT_RESULT: begin
          wd_cnt <= wd_cnt + TO_WIDTH'(1);
          if (timeout_ev) begin
            flush <= 1'b1;
            error <= 1'b1;
          end
          if (advance) begin
            if (last_tri) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx         <= idx + TRI_ID_WIDTH'(1);
              fetch_addr  <= idx + TRI_ID_WIDTH'(1);
              fetch_valid <= 1'b1;
              state       <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_emitted (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clr(start_acc), .inc(emit_ev), .count(emitted_cnt)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_culled (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clr(start_acc), .inc(cull_ev), .count(culled_cnt)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clr(start_acc), .inc(timeout_ev), .count(timeout_cnt)
  );

  assign bus.busy_out          = busy;
  assign bus.done_out          = done;
  assign bus.fetch_valid_out   = fetch_valid;
  assign bus.fetch_addr_out    = fetch_addr;
  assign bus.pp_valid_out      = pp_valid;
  assign bus.pp_flush_out      = flush;
  assign bus.error_out         = error;
  assign bus.rast_tri_id_out   = rast_tri_id;
  assign bus.rast_valid_out    = in_result & bus.pp_valid_in & ~bus.pp_short_circuit_in;
  assign bus.pp_ready_out      = in_result & bus.rast_ready_in;
  assign bus.emitted_count_out = emitted_cnt;
  assign bus.culled_count_out  = culled_cnt;
  assign bus.timeout_count_out = timeout_cnt;

endmodule

// File: tb/tb_pre_proc_scheduler.sv
// Directed bench: scripted memory/pre-processor/rasterizer responder, per-frame reference lists.
module tb_pre_proc_scheduler;

  localparam int M_NORM = 0;
  localparam int M_SC   = 1;
  localparam int M_SCV  = 2;
  localparam int M_HANG = 3;

  logic clk_in;
  logic rst_n_in;

  pre_proc_scheduler_if #(.TRI_ID_WIDTH(16), .CNT_WIDTH(16)) sif ();
  pre_proc_scheduler_if #(.TRI_ID_WIDTH(16), .CNT_WIDTH(16)) tif ();

  pre_proc_scheduler #(.TRI_ID_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(sif)
  );
  pre_proc_scheduler #(.TRI_ID_WIDTH(16), .CNT_WIDTH(16), .TIMEOUT_CYCLES(8)) dut_to (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(tif)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int checks = 0;
  int passes = 0;
  int done_seen = 0;
  int mode [8];
  int lat [8];
  int stall [8];
  logic [15:0] exp_fetch [$];
  logic [15:0] exp_emit [$];
  int beat_len [$];
  int exp_n_emit, exp_n_cull;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_script();
    for (int i = 0; i < 8; i++) begin
      mode[i] = M_NORM; lat[i] = 0; stall[i] = 0;
    end
  endtask

  // Reference: every index is fetched in order; only non-culled, non-hung ones reach the rasterizer.
  task automatic build_model(input int n);
    exp_fetch.delete(); exp_emit.delete();
    exp_n_emit = 0; exp_n_cull = 0;
    for (int i = 0; i < n; i++) begin
      exp_fetch.push_back(16'(i));
      if (mode[i] == M_NORM) begin
        exp_emit.push_back(16'(i)); exp_n_emit++;
      end else if (mode[i] == M_SC || mode[i] == M_SCV) begin
        exp_n_cull++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(sif.busy_out), 0);
    chk({tag, "_done"}, int'(sif.done_out), 0);
    chk({tag, "_fetch_valid"}, int'(sif.fetch_valid_out), 0);
    chk({tag, "_fetch_addr"}, int'(sif.fetch_addr_out), 0);
    chk({tag, "_pp_valid"}, int'(sif.pp_valid_out), 0);
    chk({tag, "_pp_ready"}, int'(sif.pp_ready_out), 0);
    chk({tag, "_flush"}, int'(sif.pp_flush_out), 0);
    chk({tag, "_rast_valid"}, int'(sif.rast_valid_out), 0);
    chk({tag, "_rast_id"}, int'(sif.rast_tri_id_out), 0);
    chk({tag, "_emitted"}, int'(sif.emitted_count_out), 0);
    chk({tag, "_culled"}, int'(sif.culled_count_out), 0);
    chk({tag, "_timeouts"}, int'(sif.timeout_count_out), 0);
    chk({tag, "_error"}, int'(sif.error_out), 0);
  endtask

  task automatic run_frame(input int n, input int hold, output int cyc);
    int d0;
    build_model(n);
    beat_len.delete();
    d0 = done_seen;
    @(posedge clk_in); #1;
    sif.num_tris_in = 16'(n); sif.start_in = 1'b1;
    for (int h = 1; h < hold; h++) begin
      @(posedge clk_in); #1;
      sif.num_tris_in = 16'd7;
    end
    @(posedge clk_in); #1;
    sif.start_in = 1'b0; sif.num_tris_in = 16'(n);
    @(negedge clk_in);
    chk("busy_after_start", int'(sif.busy_out), 1);
    cyc = 1;
    while (!sif.done_out && cyc < 3000) begin
      @(negedge clk_in); cyc++;
    end
    chk("frame_done", int'(sif.done_out), 1);
    chk("emitted_count", int'(sif.emitted_count_out), exp_n_emit);
    chk("culled_count", int'(sif.culled_count_out), exp_n_cull);
    chk("timeout_count", int'(sif.timeout_count_out), 0);
    chk("error_clear", int'(sif.error_out), 0);
    chk("fetches_left", exp_fetch.size(), 0);
    chk("emits_left", exp_emit.size(), 0);
    @(negedge clk_in);
    chk("done_one_cycle", int'(sif.done_out), 0);
    chk("busy_after_done", int'(sif.busy_out), 0);
    #1;
    chk("done_pulse_count", done_seen - d0, 1);
  endtask

  // Responder: memory returns data one cycle after a request, pre-processor follows the script.
  initial begin
    int cur, lat_left, stall_left;
    logic waiting, f_hs, i_hs, r_hs, sc_obs;
    logic [15:0] addr;
    cur = 0; lat_left = 0; stall_left = 0; waiting = 1'b0;
    sif.fetch_ready_in = 1'b1; sif.fetch_data_valid_in = 1'b0; sif.pp_ready_in = 1'b1;
    sif.pp_valid_in = 1'b0; sif.pp_short_circuit_in = 1'b0; sif.rast_ready_in = 1'b1;
    forever begin
      @(negedge clk_in);
      f_hs   = sif.fetch_valid_out & sif.fetch_ready_in;
      i_hs   = sif.pp_valid_out & sif.pp_ready_in;
      r_hs   = sif.rast_valid_out & sif.rast_ready_in;
      sc_obs = sif.pp_short_circuit_in;
      addr   = sif.fetch_addr_out;
      @(posedge clk_in); #1;
      if (!rst_n_in) begin
        waiting = 1'b0; stall_left = 0;
        sif.fetch_data_valid_in = 1'b0; sif.pp_valid_in = 1'b0;
        sif.pp_short_circuit_in = 1'b0; sif.rast_ready_in = 1'b1;
        continue;
      end
      if (sc_obs) begin
        sif.pp_short_circuit_in = 1'b0; sif.pp_valid_in = 1'b0;
      end
      if (r_hs) begin
        sif.pp_valid_in = 1'b0; sif.rast_ready_in = 1'b1;
      end else if (sif.pp_valid_in && stall_left > 0) begin
        stall_left--;
        sif.rast_ready_in = (stall_left == 0);
      end
      if (f_hs) begin
        cur = int'(addr) & 7;
        sif.fetch_data_valid_in = 1'b1;
      end
      if (i_hs) begin
        sif.fetch_data_valid_in = 1'b0;
        lat_left = lat[cur]; waiting = 1'b1;
      end
      if (waiting) begin
        if (lat_left == 0) begin
          waiting = 1'b0;
          case (mode[cur])
            M_NORM: begin
              sif.pp_valid_in = 1'b1; stall_left = stall[cur];
              sif.rast_ready_in = (stall_left == 0);
            end
            M_SC:  sif.pp_short_circuit_in = 1'b1;
            M_SCV: begin sif.pp_short_circuit_in = 1'b1; sif.pp_valid_in = 1'b1; end
            default: ;
          endcase
        end else begin
          lat_left--;
        end
      end
    end
  end

  // Per-cycle compare against the reference lists.
  initial begin
    logic prev_stall;
    logic [15:0] prev_id;
    int run;
    prev_stall = 1'b0; prev_id = '0; run = 0;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        prev_stall = 1'b0; run = 0;
        continue;
      end
      if (sif.fetch_valid_out && sif.fetch_ready_in) begin
        chk("fetch_expected", int'(exp_fetch.size() != 0), 1);
        if (exp_fetch.size() != 0) chk("fetch_addr", int'(sif.fetch_addr_out), int'(exp_fetch.pop_front()));
      end
      chk("one_in_flight", int'(sif.fetch_valid_out & sif.rast_valid_out), 0);
      if (prev_stall) begin
        chk("rast_valid_held", int'(sif.rast_valid_out), 1);
        chk("rast_id_held", int'(sif.rast_tri_id_out), int'(prev_id));
      end
      if (sif.rast_valid_out) begin
        run++;
        chk("pp_ready_pass", int'(sif.pp_ready_out), int'(sif.rast_ready_in));
        if (sif.rast_ready_in) begin
          chk("emit_expected", int'(exp_emit.size() != 0), 1);
          if (exp_emit.size() != 0) chk("rast_id", int'(sif.rast_tri_id_out), int'(exp_emit.pop_front()));
          beat_len.push_back(run);
          run = 0;
        end
      end
      prev_stall = sif.rast_valid_out & ~sif.rast_ready_in;
      prev_id = sif.rast_tri_id_out;
      if (sif.done_out) done_seen++;
    end
  end

  initial begin
    int cyc, k, d0, issue_cyc, flush_cyc, flushes, dones;
    logic id1_issue;
    rst_n_in = 1'b0;
    sif.start_in = 1'b0; sif.num_tris_in = '0;
    tif.start_in = 1'b0; tif.num_tris_in = '0;
    tif.fetch_ready_in = 1'b1; tif.fetch_data_valid_in = 1'b1; tif.pp_ready_in = 1'b1;
    tif.pp_valid_in = 1'b0; tif.pp_short_circuit_in = 1'b0; tif.rast_ready_in = 1'b1;
    clear_script();
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Three projected triangles; start held while busy with a different count.
    clear_script(); lat[1] = 2; lat[2] = 1;
    run_frame(3, 3, cyc);
    chk("f1_emitted_lit", int'(sif.emitted_count_out), 3);
    chk("f1_culled_lit", int'(sif.culled_count_out), 0);
    chk("f1_beats_lit", beat_len.size(), 3);

    // Cull on id 1, cull coincident with valid on id 3.
    clear_script(); mode[1] = M_SC; mode[3] = M_SCV; lat[3] = 1;
    run_frame(4, 1, cyc);
    chk("f2_emitted_lit", int'(sif.emitted_count_out), 2);
    chk("f2_culled_lit", int'(sif.culled_count_out), 2);

    // Rasterizer stalls id 0 for ten cycles.
    clear_script(); stall[0] = 10;
    run_frame(2, 1, cyc);
    chk("f3_stall_beat_len", (beat_len.size() > 0) ? beat_len[0] : -1, 11);
    chk("f3_emitted_lit", int'(sif.emitted_count_out), 2);

    // Empty frame.
    clear_script();
    run_frame(0, 1, cyc);
    chk("f4_done_latency", int'(cyc <= 2), 1);
    chk("f4_emitted_lit", int'(sif.emitted_count_out), 0);

    // Reset while waiting on a hung pre-processor.
    clear_script(); mode[1] = M_HANG;
    build_model(3);
    @(posedge clk_in); #1;
    sif.num_tris_in = 16'd3; sif.start_in = 1'b1;
    @(posedge clk_in); #1;
    sif.start_in = 1'b0;
    k = 0;
    while (!(sif.pp_valid_out && sif.fetch_addr_out == 16'd1) && k < 200) begin
      @(negedge clk_in); k++;
    end
    chk("reach_id1_issue", int'(k < 200), 1);
    repeat (3) @(negedge clk_in);
    chk("pre_reset_emitted", int'(sif.emitted_count_out), 1);
    chk("pre_reset_busy", int'(sif.busy_out), 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    d0 = done_seen;
    exp_fetch.delete(); exp_emit.delete();
    repeat (3) begin
      @(negedge clk_in);
      chk("no_done_in_reset", int'(sif.done_out), 0);
    end
    rst_n_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("no_done_after_reset", done_seen - d0, 0);
    clear_script();
    run_frame(2, 1, cyc);
    chk("f6_emitted_lit", int'(sif.emitted_count_out), 2);

    // Watchdog instance (timeout 8): id 0 never answers, id 1 answers at once.
    @(posedge clk_in); #1;
    tif.num_tris_in = 16'd2; tif.start_in = 1'b1;
    @(posedge clk_in); #1;
    tif.start_in = 1'b0;
    issue_cyc = -1; flush_cyc = -1; flushes = 0; dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      if (issue_cyc < 0 && tif.pp_valid_out && tif.fetch_addr_out == 16'd0) issue_cyc = c;
      if (tif.pp_flush_out) begin
        flushes++;
        if (flush_cyc < 0) flush_cyc = c;
      end
      if (tif.done_out) dones++;
      id1_issue = tif.pp_valid_out & (tif.fetch_addr_out == 16'd1);
      @(posedge clk_in); #1;
      tif.pp_valid_in = id1_issue;
    end
    chk("to_issue_seen", int'(issue_cyc >= 0), 1);
    chk("to_wait_cycles", flush_cyc - issue_cyc - 1, 8);
    chk("to_flush_pulses", flushes, 1);
    chk("to_timeout_count", int'(tif.timeout_count_out), 1);
    chk("to_error", int'(tif.error_out), 1);
    chk("to_emitted", int'(tif.emitted_count_out), 1);
    chk("to_culled", int'(tif.culled_count_out), 0);
    chk("to_done_pulses", dones, 1);
    chk("to_idle", int'(tif.busy_out), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pre_proc_scheduler.md
Name: pre_proc_scheduler

Overview:
- Frame-level sequencer for the three-vertex projection pre-processor.
- On start, walks triangle indices 0..num_tris-1 and, for each triangle:
  - requests it from triangle memory;
  - issues it to the pre-processor with a valid/ready handshake;
  - waits for either a projected result or a short-circuit (cull) indication;
  - forwards projected results downstream to the rasterizer, tagged with the triangle id.
- Exactly one triangle is in flight at a time, because a pre-processor short-circuit resets all three lanes.
- Keeps per-frame emitted, culled and timed-out counts, and a watchdog that flushes a hung pre-processor.

Parameters:
- TRI_ID_WIDTH, 16, width of triangle index and count.
- CNT_WIDTH, 16, width of the emitted, culled and timeout statistic counters.
- TIMEOUT_CYCLES, 256, maximum cycles in WAIT_RESULT before the watchdog fires (must be >= 2).
- TO_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  reset, asynchronous, active-low
- start_in  in  1  begin frame; sampled only in IDLE
- num_tris_in  in  TRI_ID_WIDTH  triangle count, latched on an accepted start
- busy_out  out  1  high in every state except IDLE
- done_out  out  1  single-cycle pulse at frame end
- fetch_valid_out  out  1  triangle memory request valid
- fetch_addr_out  out  TRI_ID_WIDTH  triangle index requested
- fetch_ready_in  in  1  memory accepts the request
- fetch_data_valid_in  in  1  triangle data is present at the pre-processor P inputs
- pp_valid_out  out  1  drives pre-processor valid_in
- pp_ready_in  in  1  pre-processor ready_out
- pp_valid_in  in  1  pre-processor valid_out
- pp_short_circuit_in  in  1  pre-processor short_circuit
- pp_ready_out  out  1  drives pre-processor ready_in
- pp_flush_out  out  1  single-cycle flush pulse, ORed into pre-processor reset by the integrator
- rast_valid_out  out  1  projected triangle valid to the rasterizer
- rast_ready_in  in  1  rasterizer accepts the triangle
- rast_tri_id_out  out  TRI_ID_WIDTH  id of the forwarded triangle
- emitted_count_out  out  CNT_WIDTH  triangles forwarded this frame
- culled_count_out  out  CNT_WIDTH  short-circuited triangles this frame
- timeout_count_out  out  CNT_WIDTH  watchdog events this frame
- error_out  out  1  sticky; set by any timeout, cleared on an accepted start

Behaviour:
- Reset values (asynchronous on rst_n_in low):
  - state = IDLE;
  - all valid outputs, done_out, pp_flush_out, busy_out and error_out = 0;
  - fetch_addr_out and rast_tri_id_out = 0;
  - all counters = 0.
- Reset mid-operation aborts the frame immediately; no done_out pulse is produced.
- IDLE:
  - On start_in=1: latch num_tris, zero the three statistic counters, clear error_out, set idx=0.
  - If num_tris==0, go to DONE; otherwise go to FETCH.
- FETCH:
  - fetch_valid_out=1 and fetch_addr_out=idx, both held stable until fetch_ready_in.
  - On handshake, go to WAIT_DATA.
- WAIT_DATA: on fetch_data_valid_in, go to ISSUE. The data must remain stable at the pre-processor until it is accepted.
- ISSUE:
  - pp_valid_out=1 until pp_ready_in=1.
  - On handshake, clear the watchdog counter and go to WAIT_RESULT.
- WAIT_RESULT (all of the following are combinational):
  - rast_valid_out = pp_valid_in & ~pp_short_circuit_in.
  - pp_ready_out = rast_ready_in.
  - rast_tri_id_out = idx, held through this state.
- WAIT_RESULT outcomes, in priority order:
  1. pp_short_circuit_in: culled_count++ and advance. Short-circuit wins if it coincides with pp_valid_in.
  2. rast_valid_out & rast_ready_in: emitted_count++ and advance.
  3. Watchdog counter reaches TIMEOUT_CYCLES-1 with neither event: pulse pp_flush_out for one cycle, timeout_count++, set error_out, and advance (the triangle is dropped).
- The watchdog counts every WAIT_RESULT cycle, including cycles stalled on rast_ready_in. Backpressure longer than the timeout is therefore treated as a hang.
- Advance:
  - If idx == num_tris-1, go to DONE.
  - Otherwise idx++ and go to FETCH. idx never wraps.
- Minimum per-triangle overhead is 1 cycle each in FETCH, WAIT_DATA and ISSUE, plus the pre-processor latency.
- DONE: done_out=1 for exactly one cycle, then go to IDLE; counters hold their values until the next start.
- start_in while busy_out=1 is ignored.
- Counters saturate at all-ones; they do not wrap.
- All outputs are registered except the combinational WAIT_RESULT pass-throughs (rast_valid_out, pp_ready_out).

Decomposition:
- Shared package pre_proc_sched_pkg:
  - enum sched_state_t {IDLE, FETCH, WAIT_DATA, ISSUE, WAIT_RESULT, DONE};
  - localparam default TIMEOUT_CYCLES.
- One sub-module: sat_counter (parameterised width, clear and inc inputs, saturating), instantiated three times for the statistic counters.
- The watchdog is an inline counter.

Test Plan:
- num_tris=3, all triangles project, rast_ready_in=1 -> fetch addrs 0,1,2; three rast_valid_out beats with ids 0,1,2; emitted=3, culled=0; done_out pulses once; busy_out then low.
- num_tris=4, short-circuit asserted on id 1, and short-circuit coincident with pp_valid_in on id 3 -> emitted=2 (ids 0,2), culled=2; no rast_valid_out for ids 1 or 3.
- num_tris=2, rast_ready_in held low 10 cycles on id 0 -> rast_valid_out and rast_tri_id_out=0 stay stable; pp_ready_out low until acceptance; fetch of id 1 starts only after acceptance.
- TIMEOUT_CYCLES=8, pre-processor never responds on id 0 of 2 -> pp_flush_out pulses after 8 WAIT_RESULT cycles; timeout=1; error_out=1; id 1 still processed; done_out pulses.
- num_tris=0 -> done_out pulses within 2 cycles of start; no fetch; counters 0. A second start_in issued while busy -> ignored.
- rst_n_in asserted during WAIT_RESULT -> all outputs zero immediately (asynchronous); no done_out; a fresh start afterwards behaves normally with counters restarting from 0.
